// File: rtl/hi_arbiter_rr.sv
// hi_arbiter_rr: shares one device-side register bus among NUM_HOSTS hosts.
//
// Ports:
//   ifclk, reset            clock, synchronous active-high reset
//   I_di_*                  packed per-host request buses (host k at slice k)
//   I_lock_arbiter          per-host request to keep the bus between transfers
//   O_di_*                  packed per-host returns; only the granted host sees
//                           device returns, and not during the blank cycle
//   di_*  (out)             device-side bus, a mux of the granted host's inputs
//   di_*  (in)              device-side returns
//   active_host_num         currently granted host
//   lock_timeout            one-cycle pulse when a held lock is overridden
//
// Arbitration happens only while the granted host is idle and not holding
// a lock. A read request from a host that is not granted is remembered as a
// fault. When that host is later granted, its request is replayed as a
// single-cycle di_read_req pulse.
module hi_arbiter_rr #(
  parameter int NUM_HOSTS = 4,
  parameter int RR_MODE   = 1,
  parameter int LOCK_MAX  = 0,
  localparam int HW = (NUM_HOSTS > 1) ? $clog2(NUM_HOSTS) : 1
) (
  input  logic                      ifclk,
  input  logic                      reset,
  input  logic [16*NUM_HOSTS-1:0]   I_di_term_addr,
  input  logic [32*NUM_HOSTS-1:0]   I_di_reg_addr,
  input  logic [32*NUM_HOSTS-1:0]   I_di_len,
  input  logic [32*NUM_HOSTS-1:0]   I_di_reg_datai,
  input  logic [NUM_HOSTS-1:0]      I_di_read_mode,
  input  logic [NUM_HOSTS-1:0]      I_di_read_req,
  input  logic [NUM_HOSTS-1:0]      I_di_read,
  input  logic [NUM_HOSTS-1:0]      I_di_write_mode,
  input  logic [NUM_HOSTS-1:0]      I_di_write,
  input  logic [NUM_HOSTS-1:0]      I_lock_arbiter,
  output logic [NUM_HOSTS-1:0]      O_di_read_rdy,
  output logic [NUM_HOSTS-1:0]      O_di_write_rdy,
  output logic [32*NUM_HOSTS-1:0]   O_di_reg_datao,
  output logic [16*NUM_HOSTS-1:0]   O_di_transfer_status,
  output logic [15:0]               di_term_addr,
  output logic [31:0]               di_reg_addr,
  output logic [31:0]               di_len,
  output logic [31:0]               di_reg_datai,
  output logic                      di_read_mode,
  output logic                      di_read_req,
  output logic                      di_read,
  output logic                      di_write_mode,
  output logic                      di_write,
  input  logic                      di_read_rdy,
  input  logic                      di_write_rdy,
  input  logic [31:0]               di_reg_datao,
  input  logic [15:0]               di_transfer_status,
  output logic [HW-1:0]             active_host_num,
  output logic                      lock_timeout
);

  logic [HW-1:0]        host_q, host_d;
  logic                 blank_q, blank_d;
  logic [NUM_HOSTS-1:0] fault_q, fault_d;
  logic                 replay_q, replay_d;
  logic [31:0]          cnt_q, cnt_d;
  logic                 lock_exp_q, lock_exp_d;
  logic                 lock_to_q, lock_to_d;

  logic [NUM_HOSTS-1:0] r, others;
  logic [HW-1:0]        pick;
  logic [HW:0]          idx;
  logic [31:0]          cnt_inc;
  logic                 busy, arb_en, change, lock_inc, expire_hit;

  // Device-side bus follows the granted host combinationally.
  assign di_term_addr  = I_di_term_addr[{host_q, 4'b0} +: 16];
  assign di_reg_addr   = I_di_reg_addr[{host_q, 5'b0} +: 32];
  assign di_len        = I_di_len[{host_q, 5'b0} +: 32];
  assign di_reg_datai  = I_di_reg_datai[{host_q, 5'b0} +: 32];
  assign di_read_mode  = I_di_read_mode[host_q];
  assign di_read       = I_di_read[host_q];
  assign di_write_mode = I_di_write_mode[host_q];
  assign di_write      = I_di_write[host_q];
  assign di_read_req   = I_di_read_req[host_q] | replay_q;

  assign active_host_num = host_q;
  assign lock_timeout    = lock_to_q;

  // Returns are steered to the granted host; the blank cycle after a grant
  // change hides any return still in flight for the previous owner.
  always_comb begin
    O_di_read_rdy        = '0;
    O_di_write_rdy       = '0;
    O_di_reg_datao       = '0;
    O_di_transfer_status = '0;
    for (int k = 0; k < NUM_HOSTS; k++) begin
      if (host_q == HW'(k) && !blank_q) begin
        O_di_read_rdy[k]                = di_read_rdy;
        O_di_write_rdy[k]               = di_write_rdy;
        O_di_reg_datao[32*k +: 32]      = di_reg_datao;
        O_di_transfer_status[16*k +: 16] = di_transfer_status;
      end
    end
  end

  always_comb begin
    r              = I_di_read_mode | I_di_write_mode;
    others         = r;
    others[host_q] = 1'b0;
    busy   = di_read_mode | di_write_mode | (I_lock_arbiter[host_q] & ~lock_exp_q);
    arb_en = !busy && !replay_q && !fault_q[host_q] && (r != '0);

    // Candidate selection. The round-robin scan runs from the farthest
    // offset to the nearest, so the last match is the first host after the
    // current one. The current host itself sits at offset NUM_HOSTS.
    pick = host_q;
    idx  = '0;
    if (RR_MODE == 0) begin
      for (int k = 0; k < NUM_HOSTS; k++)
        if (r[k]) pick = HW'(k);
    end else begin
      for (int i = NUM_HOSTS; i >= 1; i--) begin
        idx = {1'b0, host_q} + (HW+1)'(i);
        if (idx >= (HW+1)'(NUM_HOSTS)) idx = idx - (HW+1)'(NUM_HOSTS);
        if (r[idx[HW-1:0]]) pick = idx[HW-1:0];
      end
    end

    change  = arb_en && (pick != host_q);
    host_d  = change ? pick : host_q;
    blank_d = change;

    for (int k = 0; k < NUM_HOSTS; k++)
      fault_d[k] = (host_q == HW'(k)) ? 1'b0 : (fault_q[k] | I_di_read_req[k]);

    // The fault clears one cycle after grant. Masking with replay_q still
    // keeps the replay to a single pulse.
    replay_d = fault_q[host_q] & ~replay_q;

    // The lock counts only while it actually keeps another host waiting.
    lock_inc   = I_lock_arbiter[host_q] & ~di_read_mode & ~di_write_mode & (|others);
    cnt_inc    = cnt_q + 32'd1;
    cnt_d      = lock_inc ? cnt_inc : 32'd0;
    expire_hit = (LOCK_MAX != 0) && lock_inc && !lock_exp_q && (cnt_inc == 32'(LOCK_MAX));
    lock_to_d  = expire_hit;
    if (change || !I_lock_arbiter[host_q]) lock_exp_d = 1'b0;
    else if (expire_hit)                   lock_exp_d = 1'b1;
    else                                   lock_exp_d = lock_exp_q;
  end

  always_ff @(posedge ifclk) begin
    if (reset) begin
      host_q     <= '0;
      blank_q    <= 1'b0;
      fault_q    <= '0;
      replay_q   <= 1'b0;
      cnt_q      <= '0;
      lock_exp_q <= 1'b0;
      lock_to_q  <= 1'b0;
    end else begin
      host_q     <= host_d;
      blank_q    <= blank_d;
      fault_q    <= fault_d;
      replay_q   <= replay_d;
      cnt_q      <= cnt_d;
      lock_exp_q <= lock_exp_d;
      lock_to_q  <= lock_to_d;
    end
  end

endmodule

// File: tb/tb_hi_arbiter_rr.sv
module tb_hi_arbiter_rr;
  localparam int NH = 4;
  localparam int LM = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic [16*NH-1:0] term;
  logic [32*NH-1:0] raddr, len, wdata;
  logic [NH-1:0]    rm, rreq, rd, wm, wr, lk;

  // main DUT: round-robin, lock limit 5
  logic [NH-1:0] o_rrdy, o_wrdy;
  logic [32*NH-1:0] o_datao;
  logic [16*NH-1:0] o_stat;
  logic [15:0] d_term;
  logic [31:0] d_raddr, d_len, d_wdata;
  logic d_rmode, d_rreq, d_rd, d_wmode, d_wr;
  logic dev_rrdy, dev_wrdy;
  logic [31:0] dev_datao;
  logic [15:0] dev_stat;
  logic [1:0] act;
  logic lto;

  // second DUT: fixed priority
  logic [NH-1:0] f_rrdy, f_wrdy;
  logic [32*NH-1:0] f_datao;
  logic [16*NH-1:0] f_stat;
  logic [15:0] f_term;
  logic [31:0] f_raddr, f_len, f_wdata;
  logic f_rmode, f_rreq, f_rd, f_wmode, f_wr;
  logic fd_rrdy, fd_wrdy;
  logic [31:0] fd_datao;
  logic [15:0] fd_stat;
  logic [1:0] f_act;
  logic f_lto;

  // Simple device: ready whenever the matching mode is on, data derived from the address.
  assign dev_rrdy  = d_rmode;
  assign dev_wrdy  = d_wmode;
  assign dev_datao = d_raddr ^ 32'h5A5A5A5A;
  assign dev_stat  = d_term + 16'h0100;
  assign fd_rrdy   = f_rmode;
  assign fd_wrdy   = f_wmode;
  assign fd_datao  = f_raddr ^ 32'h5A5A5A5A;
  assign fd_stat   = f_term + 16'h0100;

  hi_arbiter_rr #(.NUM_HOSTS(NH), .RR_MODE(1), .LOCK_MAX(LM)) dut (
    .ifclk(clk), .reset(rst),
    .I_di_term_addr(term), .I_di_reg_addr(raddr), .I_di_len(len), .I_di_reg_datai(wdata),
    .I_di_read_mode(rm), .I_di_read_req(rreq), .I_di_read(rd), .I_di_write_mode(wm),
    .I_di_write(wr), .I_lock_arbiter(lk),
    .O_di_read_rdy(o_rrdy), .O_di_write_rdy(o_wrdy), .O_di_reg_datao(o_datao),
    .O_di_transfer_status(o_stat),
    .di_term_addr(d_term), .di_reg_addr(d_raddr), .di_len(d_len), .di_reg_datai(d_wdata),
    .di_read_mode(d_rmode), .di_read_req(d_rreq), .di_read(d_rd), .di_write_mode(d_wmode),
    .di_write(d_wr),
    .di_read_rdy(dev_rrdy), .di_write_rdy(dev_wrdy), .di_reg_datao(dev_datao),
    .di_transfer_status(dev_stat),
    .active_host_num(act), .lock_timeout(lto)
  );

  hi_arbiter_rr #(.NUM_HOSTS(NH), .RR_MODE(0), .LOCK_MAX(0)) dut_fp (
    .ifclk(clk), .reset(rst),
    .I_di_term_addr(term), .I_di_reg_addr(raddr), .I_di_len(len), .I_di_reg_datai(wdata),
    .I_di_read_mode(rm), .I_di_read_req(rreq), .I_di_read(rd), .I_di_write_mode(wm),
    .I_di_write(wr), .I_lock_arbiter(lk),
    .O_di_read_rdy(f_rrdy), .O_di_write_rdy(f_wrdy), .O_di_reg_datao(f_datao),
    .O_di_transfer_status(f_stat),
    .di_term_addr(f_term), .di_reg_addr(f_raddr), .di_len(f_len), .di_reg_datai(f_wdata),
    .di_read_mode(f_rmode), .di_read_req(f_rreq), .di_read(f_rd), .di_write_mode(f_wmode),
    .di_write(f_wr),
    .di_read_rdy(fd_rrdy), .di_write_rdy(fd_wrdy), .di_reg_datao(fd_datao),
    .di_transfer_status(fd_stat),
    .active_host_num(f_act), .lock_timeout(f_lto)
  );

  int n_checks, n_errs;

  task automatic chk(input string nm, input logic [127:0] a, input logic [127:0] e);
    n_checks++;
    if (a !== e) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, a, e);
    end
  endtask

  // Reference model: grant owner, blank flag, pending read-request faults,
  // replay pulse, and lock bookkeeping, all kept as plain integers and bits.
  bit          model_on;
  int          m_host, n_host;
  bit          m_blank, n_blank, m_replay, n_replay, m_exp, n_exp, m_to, n_to;
  bit [NH-1:0] m_fault, n_fault;
  int unsigned m_cnt, n_cnt;

  task automatic model_step();
    logic [NH-1:0]    ew, er;
    logic [32*NH-1:0] ed;
    logic [16*NH-1:0] es;
    bit busy, others, counting, hit;
    int k;
    ew = '0; er = '0; ed = '0; es = '0;
    for (int j = 0; j < NH; j++) begin
      if (j == m_host && !m_blank) begin
        ew[j] = wm[j];
        er[j] = rm[j];
        ed[32*j +: 32] = raddr[32*j +: 32] ^ 32'h5A5A5A5A;
        es[16*j +: 16] = term[16*j +: 16] + 16'h0100;
      end
    end
    if (model_on) begin
      chk("m_host",   act, m_host);
      chk("m_rreq",   d_rreq, rreq[m_host] | m_replay);
      chk("m_bus",    {d_term, d_raddr, d_len, d_wdata},
          {term[16*m_host +: 16], raddr[32*m_host +: 32], len[32*m_host +: 32], wdata[32*m_host +: 32]});
      chk("m_ctl",    {d_rmode, d_rd, d_wmode, d_wr}, {rm[m_host], rd[m_host], wm[m_host], wr[m_host]});
      chk("m_rdy",    {o_rrdy, o_wrdy}, {er, ew});
      chk("m_datao",  o_datao, ed);
      chk("m_status", o_stat, es);
      chk("m_lockto", lto, m_to);
    end
    if (rst) begin
      n_host = 0; n_blank = 0; n_fault = '0; n_replay = 0; n_cnt = 0; n_exp = 0; n_to = 0;
    end else begin
      n_host = m_host;
      busy = rm[m_host] || wm[m_host] || (lk[m_host] && !m_exp);
      if (!busy && !m_replay && !m_fault[m_host]) begin
        for (int d = 1; d <= NH; d++) begin
          k = (m_host + d) % NH;
          if (rm[k] || wm[k]) begin
            n_host = k;
            break;
          end
        end
      end
      n_blank = (n_host != m_host);
      for (int j = 0; j < NH; j++)
        n_fault[j] = (j == m_host) ? 1'b0 : (m_fault[j] | rreq[j]);
      n_replay = m_fault[m_host] && !m_replay;
      others = 0;
      for (int j = 0; j < NH; j++)
        if (j != m_host && (rm[j] || wm[j])) others = 1;
      counting = lk[m_host] && !rm[m_host] && !wm[m_host] && others;
      n_cnt = counting ? m_cnt + 1 : 0;
      hit = counting && !m_exp && (n_cnt == LM);
      n_to = hit;
      n_exp = (n_blank || !lk[m_host]) ? 1'b0 : (hit ? 1'b1 : m_exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    model_step();
    @(posedge clk);
    #1;
    m_host = n_host; m_blank = n_blank; m_fault = n_fault; m_replay = n_replay;
    m_cnt = n_cnt; m_exp = n_exp; m_to = n_to;
  endtask

  task automatic do_reset();
    rm = '0; wm = '0; rreq = '0; rd = '0; wr = '0; lk = '0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  typedef struct {
    logic [NH-1:0] rm, wm, lk;
    int            host;
    logic [NH-1:0] wrdy;
  } vec_t;
  vec_t tbl[16];

  initial begin
    int h, prev, age, wcnt, ng, cnt, first, pulses, seen;
    int grants[4];
    n_checks = 0; n_errs = 0; model_on = 0;
    m_host = 0; m_blank = 0; m_fault = '0; m_replay = 0; m_cnt = 0; m_exp = 0; m_to = 0;
    for (int k = 0; k < NH; k++) begin
      term[16*k +: 16]  = 16'h1000 + 16'(k);
      raddr[32*k +: 32] = 32'hA000_0000 + 32'(k);
      len[32*k +: 32]   = 32'h0000_0040 + 32'(k);
      wdata[32*k +: 32] = 32'hD000_0000 + 32'(k);
    end

    // reset state
    do_reset();
    model_on = 1;
    #1;
    chk("rst_host", act, 0);
    chk("rst_rdy", {o_rrdy, o_wrdy}, 0);
    chk("rst_lockto", lto, 0);
    chk("rst_rreq", d_rreq, 0);
    chk("rst_addr", d_raddr, 32'hA000_0000);

    // round-robin arbitration walk from reset
    tbl[0]  = '{4'b0000, 4'b0000, 4'b0000, 0, 4'b0000};
    tbl[1]  = '{4'b0000, 4'b0100, 4'b0000, 2, 4'b0000};
    tbl[2]  = '{4'b0000, 4'b0100, 4'b0000, 2, 4'b0100};
    tbl[3]  = '{4'b0000, 4'b1110, 4'b0000, 2, 4'b0100};
    tbl[4]  = '{4'b0000, 4'b1010, 4'b0000, 3, 4'b0000};
    tbl[5]  = '{4'b0000, 4'b1010, 4'b0000, 3, 4'b1000};
    tbl[6]  = '{4'b0000, 4'b0011, 4'b0000, 0, 4'b0000};
    tbl[7]  = '{4'b0000, 4'b0011, 4'b0000, 0, 4'b0001};
    tbl[8]  = '{4'b0000, 4'b0010, 4'b0000, 1, 4'b0000};
    tbl[9]  = '{4'b0001, 4'b0010, 4'b0000, 1, 4'b0010};
    tbl[10] = '{4'b0001, 4'b0000, 4'b0000, 0, 4'b0000};
    tbl[11] = '{4'b0000, 4'b0000, 4'b0001, 0, 4'b0000};
    tbl[12] = '{4'b0000, 4'b0100, 4'b0001, 0, 4'b0000};
    tbl[13] = '{4'b0000, 4'b0100, 4'b0000, 2, 4'b0000};
    tbl[14] = '{4'b0000, 4'b0100, 4'b0000, 2, 4'b0100};
    tbl[15] = '{4'b0000, 4'b0000, 4'b0000, 2, 4'b0000};
    for (int i = 0; i < 16; i++) begin
      rm = tbl[i].rm; wm = tbl[i].wm; lk = tbl[i].lk;
      tick();
      chk($sformatf("tbl%0d_host", i), act, tbl[i].host);
      chk($sformatf("tbl%0d_wrdy", i), o_wrdy, tbl[i].wrdy);
    end

    // hosts 1..3 stream writes, each stepping aside for one cycle after 8
    do_reset();
    prev = 0; age = 0; wcnt = 0; ng = 0;
    for (int i = 0; i < 4; i++) grants[i] = -1;
    for (int cyc = 0; cyc < 200 && ng < 4; cyc++) begin
      h = int'(act);
      if (h != prev) begin
        grants[ng] = h; ng++; prev = h; age = 0; wcnt = 0;
      end
      wm = 4'b1110;
      if (wcnt == 8) wm[h] = 1'b0;
      #1;
      if (ng > 0 && age == 0) chk("rr_blank", o_wrdy[h], 0);
      if (ng > 0 && age == 1) chk("rr_after_blank", o_wrdy[h], 1);
      if (o_wrdy[h] && wcnt < 8) wcnt++;
      age++;
      tick();
    end
    chk("rr_grant_count", ng, 4);
    chk("rr_order", {grants[0][3:0], grants[1][3:0], grants[2][3:0], grants[3][3:0]}, 16'h1231);

    // fixed priority: hosts 0 and 2 together from an idle bus
    do_reset();
    wm = 4'b1000; tick();
    wm = 4'b0000; tick();
    chk("fp_idle_host", f_act, 3);
    wm = 4'b0101; tick();
    chk("fp_grant", f_act, 2);
    chk("fp_blank", f_wrdy, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("fp_hold", f_act, 2);
      chk("fp_h0_wrdy", f_wrdy[0], 0);
      chk("fp_h2_wrdy", f_wrdy[2], 1);
    end
    chk("fp_bus", {f_term, f_raddr, f_len, f_wdata},
        {term[47:32], raddr[95:64], len[95:64], wdata[95:64]});
    chk("fp_ctl", {f_rmode, f_rreq, f_rd, f_wmode, f_wr, f_lto}, 6'b000100);
    chk("fp_ret", {f_rrdy, f_datao[95:64], f_stat[47:32], f_datao[31:0]},
        {4'b0000, raddr[95:64] ^ 32'h5A5A5A5A, term[47:32] + 16'h0100, 32'h0});

    // deferred read request replayed once after grant
    do_reset();
    rm = 4'b0001; tick();
    rm = 4'b0011; rreq = 4'b0010; tick();
    rreq = 4'b0000; tick();
    rm = 4'b0010; tick();
    chk("rp_grant", act, 1);
    cnt = 0; first = -1;
    for (int i = 0; i < 5; i++) begin
      #1;
      if (d_rreq) begin cnt++; if (first < 0) first = i; end
      tick();
    end
    chk("rp_pulses", cnt, 1);
    chk("rp_pulse_pos", first, 1);
    rm = 4'b0100; tick();
    chk("rp_release", act, 2);

    // lock override after LOCK_MAX counted cycles
    do_reset();
    lk = 4'b0001; wm = 4'b1000;
    pulses = 0; seen = -1;
    for (int i = 0; i < 12; i++) begin
      #1;
      if (lto) begin pulses++; if (seen < 0) seen = i; end
      if (i == 5) chk("lk_hold", act, 0);
      if (i == 6) chk("lk_grant", act, 3);
      tick();
    end
    chk("lk_pulses", pulses, 1);
    chk("lk_pulse_pos", seen, 5);
    lk = 4'b0000; wm = 4'b0000;

    // reset in the middle of a host 2 write, with a pending fault on host 0
    do_reset();
    wm = 4'b0100; tick();
    tick();
    rreq = 4'b0001; tick();
    rreq = 4'b0000;
    rst = 1'b1; tick();
    rst = 1'b0;
    #1;
    chk("mr_host", act, 0);
    chk("mr_rdy", {o_rrdy, o_wrdy}, 0);
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("mr_no_replay", d_rreq, 0);
      tick();
    end

    // randomized traffic against the model
    do_reset();
    for (int cyc = 0; cyc < 1500; cyc++) begin
      for (int k = 0; k < NH; k++) begin
        if ($urandom_range(0, 7) == 0)  wm[k] = ~wm[k];
        if ($urandom_range(0, 9) == 0)  rm[k] = ~rm[k];
        if ($urandom_range(0, 11) == 0) lk[k] = ~lk[k];
        rreq[k] = ($urandom_range(0, 15) == 0);
        rd[k]   = 1'($urandom_range(0, 1));
        wr[k]   = 1'($urandom_range(0, 1));
        term[16*k +: 16]  = 16'($urandom());
        raddr[32*k +: 32] = $urandom();
        len[32*k +: 32]   = $urandom();
        wdata[32*k +: 32] = $urandom();
      end
      rst = ($urandom_range(0, 199) == 0);
      tick();
    end
    rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule
